sonic_tx_arbiter: RTL and testbench

Shares the single PCIe backend transmit interface (tx_req/tx_desc/tx_dv/tx_data) among NUM_REQ transmit clients: command-response controller, RX DMA updater and IRQ generator.
- Drives each client's tx_sel and tx_ready_others.
- Muxes the granted client's TX signals onto the backend.
- Routes tx_ack/tx_ws back to the granted client only.
- Sits between the per-port clients and the PCIe application-layer TX port.

---
 rtl/sonic_tx_arb_pkg.sv | 15 +
 rtl/sonic_rr_pick.sv | 29 ++
 rtl/sonic_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_sonic_tx_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_tx_arb_pkg.sv
// Shared types and constants for the SONIC PCIe TX arbiter.
package sonic_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_OWNED   = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam int GRANT_TIMEOUT_DEF = 64;
  localparam int TX_DESC_W         = 128;
  localparam int TX_DATA_W         = 128;

endpackage

// File: rtl/sonic_rr_pick.sv
// Combinational round-robin picker: first set req bit after rr_ptr, wrapping.
module sonic_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int c;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sonic_tx_arbiter.sv
// Shares the PCIe backend TX port among NUM_REQ clients (round-robin grant, timeout revoke).
// Define SONIC_TX_ARB_PRIO_EN to give client 0 strict priority at arbitration.
module sonic_tx_arbiter
  import sonic_tx_arb_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int IDX_W         = $clog2(NUM_REQ),
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic                           clk_in,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             cl_tx_ready,
  input  logic [NUM_REQ-1:0]             cl_tx_busy,
  input  logic [NUM_REQ-1:0]             cl_tx_req,
  input  logic [TX_DESC_W*NUM_REQ-1:0]   cl_tx_desc,
  input  logic [NUM_REQ-1:0]             cl_tx_dv,
  input  logic [NUM_REQ-1:0]             cl_tx_dfr,
  input  logic [TX_DATA_W*NUM_REQ-1:0]   cl_tx_data,
  input  logic [NUM_REQ-1:0]             cl_tx_err,
  output logic [NUM_REQ-1:0]             cl_tx_sel,
  output logic [NUM_REQ-1:0]             cl_tx_ready_others,
  output logic [NUM_REQ-1:0]             cl_tx_ack,
  output logic [NUM_REQ-1:0]             cl_tx_ws,
  output logic                           tx_req,
  output logic [TX_DESC_W-1:0]           tx_desc,
  output logic                           tx_dv,
  output logic                           tx_dfr,
  output logic [TX_DATA_W-1:0]           tx_data,
  output logic                           tx_err,
  input  logic                           tx_ack,
  input  logic                           tx_ws,
  output logic                           grant_timeout
);

  localparam int TMO_W = $clog2(GRANT_TIMEOUT + 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               active;

`ifdef SONIC_TX_ARB_PRIO_EN
  // Client 0 is handled ahead of the picker; the rest rotate among themselves.
  assign rr_req = cl_tx_ready & ~NUM_REQ'(1);
`else
  assign rr_req = cl_tx_ready;
`endif

  sonic_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (rr_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB_IDLE;
      gnt_idx <= '0;
      rr_ptr  <= IDX_W'(NUM_REQ - 1);
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_nxt;
      rr_ptr  <= rr_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt_idx;
    rr_nxt        = rr_ptr;
    tmo_nxt       = '0;
    grant_timeout = 1'b0;
    case (state)
      ARB_IDLE: begin
`ifdef SONIC_TX_ARB_PRIO_EN
        if (cl_tx_ready[0]) begin
          gnt_nxt   = '0;
          state_nxt = ARB_GRANT;
        end else
`endif
        if (pick_vld) begin
          gnt_nxt   = pick_idx;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        tmo_nxt = tmo_cnt + 1'b1;
        // busy wins over a same-cycle timeout
        if (cl_tx_busy[gnt_idx])             state_nxt = ARB_OWNED;
        else if (!cl_tx_ready[gnt_idx])      state_nxt = ARB_RELEASE;
        else if (tmo_cnt == TMO_W'(GRANT_TIMEOUT - 1)) begin
          state_nxt     = ARB_RELEASE;
          grant_timeout = 1'b1;
        end
      end
      ARB_OWNED: begin
        if (!cl_tx_busy[gnt_idx]) state_nxt = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        rr_nxt    = gnt_idx;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign active = (state == ARB_GRANT) || (state == ARB_OWNED);
  assign gnt_oh = NUM_REQ'(1) << gnt_idx;

  always_comb begin
    cl_tx_sel          = '0;
    cl_tx_ready_others = '0;
    cl_tx_ack          = '0;
    cl_tx_ws           = '1;
    tx_req             = 1'b0;
    tx_dv              = 1'b0;
    tx_dfr             = 1'b0;
    tx_err             = 1'b0;
    tx_desc            = '0;
    tx_data            = '0;
    if (active) begin
      cl_tx_sel          = gnt_oh;
      cl_tx_ready_others = ~gnt_oh;
      cl_tx_ack          = tx_ack ? gnt_oh : '0;
      cl_tx_ws           = tx_ws ? '1 : ~gnt_oh;
      tx_req             = cl_tx_req[gnt_idx];
      tx_dv              = cl_tx_dv[gnt_idx];
      tx_dfr             = cl_tx_dfr[gnt_idx];
      tx_err             = cl_tx_err[gnt_idx];
      tx_desc            = cl_tx_desc[int'(gnt_idx)*TX_DESC_W +: TX_DESC_W];
      tx_data            = cl_tx_data[int'(gnt_idx)*TX_DATA_W +: TX_DATA_W];
    end
  end

endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// Randomized bench for sonic_tx_arbiter: model predicts grant order, monitor checks every cycle.
module tb_sonic_tx_arbiter;

  localparam int N  = 3;
  localparam int GT = 64;

  logic             clk_in = 1'b0;
  logic             rstn;
  logic [N-1:0]     cl_tx_ready, cl_tx_busy, cl_tx_req, cl_tx_dv, cl_tx_dfr, cl_tx_err;
  logic [128*N-1:0] cl_tx_desc, cl_tx_data;
  logic [N-1:0]     cl_tx_sel, cl_tx_ready_others, cl_tx_ack, cl_tx_ws;
  logic             tx_req, tx_dv, tx_dfr, tx_err, tx_ack, tx_ws, grant_timeout;
  logic [127:0]     tx_desc, tx_data;

  always #5 clk_in = ~clk_in;

  sonic_tx_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(GT)) dut (
    .clk_in(clk_in), .rstn(rstn),
    .cl_tx_ready(cl_tx_ready), .cl_tx_busy(cl_tx_busy), .cl_tx_req(cl_tx_req),
    .cl_tx_desc(cl_tx_desc), .cl_tx_dv(cl_tx_dv), .cl_tx_dfr(cl_tx_dfr),
    .cl_tx_data(cl_tx_data), .cl_tx_err(cl_tx_err),
    .cl_tx_sel(cl_tx_sel), .cl_tx_ready_others(cl_tx_ready_others),
    .cl_tx_ack(cl_tx_ack), .cl_tx_ws(cl_tx_ws),
    .tx_req(tx_req), .tx_desc(tx_desc), .tx_dv(tx_dv), .tx_dfr(tx_dfr),
    .tx_data(tx_data), .tx_err(tx_err), .tx_ack(tx_ack), .tx_ws(tx_ws),
    .grant_timeout(grant_timeout)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  int           exp_q[$];
  int           last;
  logic [N-1:0] lazy;
  int           bleft[N];
  int           hold[N];
  logic [N-1:0] s_sel;
  logic         s_gto;

  task automatic chk(string name, logic [263:0] act, logic [263:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every posted client is served once; order is rotation after the last winner.
  task automatic post(logic [N-1:0] m);
    logic [N-1:0] r;
    int w;
    for (int i = 0; i < N; i++)
      if (m[i]) hold[i] = $urandom_range(1, 5);
    cl_tx_busy  = cl_tx_busy & ~m;
    cl_tx_ready = cl_tx_ready | m;
    r = m;
    while (r != '0) begin
      w = -1;
`ifdef SONIC_TX_ARB_PRIO_EN
      if (r[0]) w = 0;
`endif
      for (int k = 1; k <= N; k++) begin
        int c = (last + k) % N;
        if (w < 0 && r[c]) w = c;
      end
      exp_q.push_back(w);
      r[w] = 1'b0;
      last = w;
    end
  endtask

  // One cycle of client behaviour, acting on the negedge after sampling outputs.
  task automatic step();
    @(negedge clk_in);
    s_sel = cl_tx_sel;
    s_gto = grant_timeout;
    for (int i = 0; i < N; i++) begin
      if (s_sel[i]) begin
        if (lazy[i]) begin
          if (s_gto) begin cl_tx_ready[i] = 1'b0; lazy[i] = 1'b0; end
        end else if (!cl_tx_busy[i]) begin
          cl_tx_busy[i] = 1'b1;
          bleft[i] = hold[i];
        end else if (bleft[i] <= 1) begin
          cl_tx_busy[i]  = 1'b0;
          cl_tx_ready[i] = 1'b0;
        end else bleft[i]--;
      end else if (!cl_tx_ready[i]) begin
        cl_tx_busy[i] = 1'($urandom_range(0, 1));
      end
    end
    for (int w = 0; w < N * 4; w++) begin
      cl_tx_desc[w*32 +: 32] = $urandom;
      cl_tx_data[w*32 +: 32] = $urandom;
    end
    cl_tx_req = N'($urandom);
    cl_tx_dv  = N'($urandom);
    cl_tx_dfr = N'($urandom);
    cl_tx_err = N'($urandom);
    tx_ack    = 1'($urandom);
    tx_ws     = 1'($urandom);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    do begin step(); n++; end
    while ((cl_tx_ready != '0 || s_sel != '0) && n < 2000);
    if (n >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: ready %0b sel %0b still active", name, cl_tx_ready, s_sel);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] prev = '0;
    logic [N-1:0] oh;
    int zrun = 100;
    int g;
    forever begin
      @(negedge clk_in);
      #2;
      if (!rstn) begin prev = '0; zrun = 100; continue; end
      if (cl_tx_sel == '0) begin
        chk("idle_bus", {tx_req, tx_dv, tx_dfr, tx_err, tx_desc, tx_data}, '0);
        chk("idle_client", {cl_tx_ready_others, cl_tx_ack, cl_tx_ws, grant_timeout},
            {{N{1'b0}}, {N{1'b0}}, {N{1'b1}}, 1'b0});
        zrun++;
      end else begin
        chk("sel_onehot", $countones(cl_tx_sel), 1);
        g = 0;
        for (int i = 0; i < N; i++) if (cl_tx_sel[i]) g = i;
        if (prev == '0) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL grant_unexpected: got client %0d expected no grant", g);
          end else chk("grant_idx", g, exp_q.pop_front());
          chk("grant_gap", zrun >= 2, 1);
        end else chk("sel_stable", cl_tx_sel, prev);
        oh = N'(1) << g;
        chk("bus_mux", {tx_req, tx_dv, tx_dfr, tx_err, tx_desc, tx_data},
            {cl_tx_req[g], cl_tx_dv[g], cl_tx_dfr[g], cl_tx_err[g],
             cl_tx_desc[g*128 +: 128], cl_tx_data[g*128 +: 128]});
        chk("client_route", {cl_tx_ready_others, cl_tx_ack, cl_tx_ws},
            {~oh, (tx_ack ? oh : {N{1'b0}}), (tx_ws ? {N{1'b1}} : ~oh)});
        zrun = 0;
      end
      prev = cl_tx_sel;
    end
  endtask

  initial begin
    int n, cnt, pos;
    rstn = 1'b0;
    cl_tx_ready = '0; cl_tx_busy = '0; cl_tx_req = '0; cl_tx_dv = '0;
    cl_tx_dfr = '0; cl_tx_err = '0; cl_tx_desc = '0; cl_tx_data = '0;
    tx_ack = 1'b0; tx_ws = 1'b0; lazy = '0; last = N - 1;
    for (int i = 0; i < N; i++) begin bleft[i] = 0; hold[i] = 1; end
    fork monitor(); join_none

    repeat (3) step();
    #1;
    chk("rst_client", {cl_tx_sel, cl_tx_ready_others, cl_tx_ack, cl_tx_ws, grant_timeout},
        {{N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b1}}, 1'b0});
    chk("rst_bus", {tx_req, tx_dv, tx_dfr, tx_err, tx_desc, tx_data}, '0);
    step();
    rstn = 1'b1;
    step();

    // single requester: grant visible one cycle after ready is sampled
    cl_tx_busy = '0;
    post(3'b001);
    step();
    chk("t1_latency", s_sel, 3'b001);
    #1;
    chk("t1_others", cl_tx_ready_others, 3'b110);
    chk("t1_desc", tx_desc, cl_tx_desc[127:0]);
    wait_done("t1");

    // client 1 never goes busy: revoked after GT grant cycles, then client 2
    lazy[1] = 1'b1;
    post(3'b110);
    n = 0; cnt = 0; pos = 0;
    do begin
      step(); n++;
      if (s_sel[1]) begin cnt++; if (s_gto) pos = cnt; end
    end while (!(cnt > 0 && !s_sel[1]) && n < GT + 20);
    chk("tmo_len", cnt, GT);
    chk("tmo_pulse_pos", pos, GT);
    wait_done("t3");

    for (int r = 0; r < 25; r++) begin
      post(N'($urandom_range(1, (1 << N) - 1)));
      wait_done("rand");
    end

    // rr_ptr left at 0, all ready: plain RR gives 1, priority build gives 0
    post(3'b001);
    wait_done("t6a");
    post(3'b111);
    wait_done("t6b");

    // reset while client 2 owns the bus
    post(3'b100);
    hold[2] = 20;
    n = 0;
    do begin step(); n++; end while (!(s_sel[2] && cl_tx_busy[2]) && n < 20);
    step(); step();
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_sel", cl_tx_sel, '0);
    chk("rst_mid_dv", tx_dv, 1'b0);
    chk("rst_mid_ws", cl_tx_ws, {N{1'b1}});
    cl_tx_ready = '0; cl_tx_busy = '0; lazy = '0; last = N - 1;
    exp_q.delete();
    step(); step();
    rstn = 1'b1;
    post(3'b111);
    wait_done("t5");

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
